// File: rtl/match_grid_led.sv
// match_grid_led: LED-grid controller for the card-matching game (ROWS x COLS cards).
// Latency: LEDs are registered one cycle behind state and inputs; FSM outputs are registered.
// Backpressure: pair_ready is held until match_valid; selects outside IDLE/ONE_UP are dropped.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   cursor, select      card index under the cursor (row-major) and pick strobe
//   clear_found         new-game strobe; clears found mask, count and picks
//   match_valid/is_match compare result from the upstream card-compare logic
//   LEDs                registered LED drive, bit i = card i
//   card1_idx/card2_idx first and second pick
//   pair_ready, busy    pair awaiting compare / FSM in WAIT_CMP or REVEAL
//   found_count, all_found  number of found cards / every card found
//
// Optional build macro MATCH_GRID_LED_BLINK_EN: when defined, the cursor LED term
// blinks with a phase that toggles every tick; otherwise the cursor LED is steady.

module match_grid_led #(
   parameter int ROWS         = 6,
   parameter int COLS         = 6,
   parameter int TICK_DIV     = 25000000,
   parameter int REVEAL_TICKS = 2,
   localparam int N           = ROWS * COLS,
   localparam int IDX_W       = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [IDX_W-1:0] cursor,
   input  logic             select,
   input  logic             clear_found,
   input  logic             match_valid,
   input  logic             is_match,
   output logic [N-1:0]     LEDs,
   output logic [IDX_W-1:0] card1_idx,
   output logic [IDX_W-1:0] card2_idx,
   output logic             pair_ready,
   output logic             busy,
   output logic [IDX_W:0]   found_count,
   output logic             all_found
);

   localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TC_W = (REVEAL_TICKS > 1) ? $clog2(REVEAL_TICKS) : 1;
   localparam logic [PS_W-1:0]  PS_MAX = PS_W'(TICK_DIV - 1);
   localparam logic [TC_W-1:0]  TC_MAX = TC_W'(REVEAL_TICKS - 1);
   localparam logic [IDX_W:0]   N_CNT  = (IDX_W + 1)'(N);
   localparam logic [IDX_W:0]   TWO    = (IDX_W + 1)'(2);

   typedef enum logic [1:0] {IDLE, ONE_UP, WAIT_CMP, REVEAL} state_t;

   state_t           state;
   logic [N-1:0]     found;
   logic [PS_W-1:0]  prescaler;
   logic [TC_W-1:0]  tick_cnt;

   logic             tick;
   logic             in_range;
   logic             cursor_found;
   logic             pick_ok;
   logic             show1;
   logic             show2;
   logic             cursor_phase;
   logic [N-1:0]     led_next;

`ifdef MATCH_GRID_LED_BLINK_EN
   logic blink;
   assign cursor_phase = blink;
`else
   assign cursor_phase = 1'b1;
`endif

   assign tick = (prescaler == PS_MAX);

   always_comb begin
      // Widen by one bit so an out-of-range index is detectable even when N is a power of two.
      in_range     = ({1'b0, cursor} < N_CNT);
      cursor_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (cursor == IDX_W'(i)) cursor_found = found[i];
      end

      pick_ok = select && in_range && !cursor_found &&
                ((state == IDLE) || ((state == ONE_UP) && (cursor != card1_idx)));

      show1 = (state != IDLE);
      show2 = (state == WAIT_CMP) || (state == REVEAL);

      led_next = '0;
      for (int i = 0; i < N; i++) begin
         led_next[i] = found[i]
                     | (in_range && (cursor == IDX_W'(i)) && cursor_phase)
                     | (show1 && (card1_idx == IDX_W'(i)))
                     | (show2 && (card2_idx == IDX_W'(i)));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         found       <= '0;
         card1_idx   <= '0;
         card2_idx   <= '0;
         pair_ready  <= 1'b0;
         busy        <= 1'b0;
         found_count <= '0;
         all_found   <= 1'b0;
         LEDs        <= '0;
         prescaler   <= '0;
         tick_cnt    <= '0;
`ifdef MATCH_GRID_LED_BLINK_EN
         blink       <= 1'b1;
`endif
      end else begin
         LEDs <= led_next;

         // Free-running prescaler, re-phased on REVEAL entry so the reveal lasts
         // exactly REVEAL_TICKS*TICK_DIV cycles.
         if (!clear_found && (state == WAIT_CMP) && match_valid && !is_match)
            prescaler <= '0;
         else if (tick)
            prescaler <= '0;
         else
            prescaler <= prescaler + 1'b1;

`ifdef MATCH_GRID_LED_BLINK_EN
         if (tick) blink <= ~blink;
`endif

         if (clear_found) begin
            state       <= IDLE;
            found       <= '0;
            found_count <= '0;
            all_found   <= 1'b0;
            card1_idx   <= '0;
            card2_idx   <= '0;
            pair_ready  <= 1'b0;
            busy        <= 1'b0;
            tick_cnt    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (pick_ok) begin
                     card1_idx <= cursor;
                     state     <= ONE_UP;
                  end
               end
               ONE_UP: begin
                  if (pick_ok) begin
                     card2_idx  <= cursor;
                     pair_ready <= 1'b1;
                     busy       <= 1'b1;
                     state      <= WAIT_CMP;
                  end
               end
               WAIT_CMP: begin
                  if (match_valid) begin
                     pair_ready <= 1'b0;
                     if (is_match) begin
                        for (int i = 0; i < N; i++) begin
                           if ((card1_idx == IDX_W'(i)) || (card2_idx == IDX_W'(i)))
                              found[i] <= 1'b1;
                        end
                        found_count <= found_count + TWO;
                        all_found   <= ((found_count + TWO) == N_CNT);
                        busy        <= 1'b0;
                        state       <= IDLE;
                     end else begin
                        tick_cnt <= '0;
                        state    <= REVEAL;
                     end
                  end
               end
               REVEAL: begin
                  if (tick) begin
                     if (tick_cnt == TC_MAX) begin
                        tick_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                     end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_match_grid_led.sv
module tb_match_grid_led;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  cursor;
   logic        select, clear_found, match_valid, is_match;
   logic [15:0] LEDs;
   logic [3:0]  card1_idx, card2_idx;
   logic        pair_ready, busy, all_found;
   logic [4:0]  found_count;

   // 3x4 grid: 4-bit cursor can address indices 12..15, which are out of range.
   logic [3:0]  cursor_s;
   logic        select_s;
   logic [11:0] LEDs_s;
   logic [3:0]  card1_s, card2_s;
   logic        pair_ready_s, busy_s, all_found_s;
   logic [4:0]  found_count_s;
   logic        zero_s;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   match_grid_led #(.ROWS(4), .COLS(4), .TICK_DIV(4), .REVEAL_TICKS(3)) u_dut (
      .clock(clock), .reset(reset), .cursor(cursor), .select(select),
      .clear_found(clear_found), .match_valid(match_valid), .is_match(is_match),
      .LEDs(LEDs), .card1_idx(card1_idx), .card2_idx(card2_idx),
      .pair_ready(pair_ready), .busy(busy), .found_count(found_count),
      .all_found(all_found)
   );

   match_grid_led #(.ROWS(3), .COLS(4), .TICK_DIV(4), .REVEAL_TICKS(3)) u_small (
      .clock(clock), .reset(reset), .cursor(cursor_s), .select(select_s),
      .clear_found(zero_s), .match_valid(zero_s), .is_match(zero_s),
      .LEDs(LEDs_s), .card1_idx(card1_s), .card2_idx(card2_s),
      .pair_ready(pair_ready_s), .busy(busy_s), .found_count(found_count_s),
      .all_found(all_found_s)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; outputs are then sampled 1 time unit later.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pick(input logic [3:0] idx);
      cursor = idx;
      select = 1'b1;
      step();
      select = 1'b0;
   endtask

   task automatic match_pair(input logic [3:0] a, input logic [3:0] b);
      pick(a);
      pick(b);
      match_valid = 1'b1;
      is_match    = 1'b1;
      step();
      match_valid = 1'b0;
      is_match    = 1'b0;
   endtask

   initial begin
      int rc;
      reset = 1'b1; cursor = 4'd5; select = 1'b0; clear_found = 1'b0;
      match_valid = 1'b0; is_match = 1'b0;
      cursor_s = 4'd0; select_s = 1'b0; zero_s = 1'b0;
      repeat (3) step();
      reset = 1'b0;

      // T1: reset state
      step();
      chk("t1_leds", LEDs, 32'h0020);
      chk("t1_card1", card1_idx, 0);
      chk("t1_card2", card2_idx, 0);
      chk("t1_pair_ready", pair_ready, 0);
      chk("t1_busy", busy, 0);
      chk("t1_found_count", found_count, 0);
      chk("t1_all_found", all_found, 0);

      // T2: repeat of first pick is ignored
      pick(4'd2);
      pick(4'd2);
      chk("t2_repeat_ignored", pair_ready, 0);
      pick(4'd9);
      chk("t2_pair_ready", pair_ready, 1);
      chk("t2_card1", card1_idx, 2);
      chk("t2_card2", card2_idx, 9);
      chk("t2_busy", busy, 1);
      step();
      chk("t2_leds", LEDs, 32'h0204);

      // T3: match
      match_valid = 1'b1; is_match = 1'b1;
      step();
      match_valid = 1'b0; is_match = 1'b0;
      chk("t3_found_count", found_count, 2);
      chk("t3_pair_ready", pair_ready, 0);
      chk("t3_busy", busy, 0);
      step();
      chk("t3_leds", LEDs, 32'h0204);
      // A pick of found card 2 must not register; the next pick becomes card1.
      pick(4'd2);
      pick(4'd0);
      chk("t3_found_pick_ignored", card1_idx, 0);
      chk("t3_no_pair", pair_ready, 0);

      // T4: mismatch reveal
      pick(4'd1);
      chk("t4_pair_ready", pair_ready, 1);
      cursor = 4'd15;
      match_valid = 1'b1; is_match = 1'b0;
      step();
      match_valid = 1'b0;
      chk("t4_pair_drop", pair_ready, 0);
      rc = 0;
      while (busy && rc < 40) begin
         if (rc == 5) chk("t4_reveal_leds", LEDs, 32'h8207);
         select = (rc < 3);
         step();
         rc++;
      end
      select = 1'b0;
      chk("t4_busy_cycles", rc, 12);
      step();
      chk("t4_after_leds", LEDs, 32'h8204);
      chk("t4_after_pair", pair_ready, 0);

      // T5: find everything
      match_pair(4'd0, 4'd1);
      match_pair(4'd3, 4'd4);
      match_pair(4'd5, 4'd6);
      match_pair(4'd7, 4'd8);
      match_pair(4'd10, 4'd11);
      match_pair(4'd12, 4'd13);
      chk("t5_count14", found_count, 14);
      chk("t5_not_all", all_found, 0);
      match_pair(4'd14, 4'd15);
      chk("t5_count16", found_count, 16);
      chk("t5_all_found", all_found, 1);
      step();
      chk("t5_leds_full", LEDs, 32'hFFFF);
      pick(4'd3);
      pick(4'd4);
      chk("t5_select_ignored", pair_ready, 0);
      // clear_found wins over a simultaneous select
      cursor = 4'd6; clear_found = 1'b1; select = 1'b1;
      step();
      clear_found = 1'b0; select = 1'b0;
      chk("t5_clr_count", found_count, 0);
      chk("t5_clr_all", all_found, 0);
      chk("t5_clr_card1", card1_idx, 0);
      chk("t5_clr_card2", card2_idx, 0);
      step();
      chk("t5_clr_leds", LEDs, 32'h0040);

      // T6: reset during WAIT_CMP with a simultaneous match
      pick(4'd3);
      pick(4'd7);
      chk("t6_pair_ready", pair_ready, 1);
      reset = 1'b1; match_valid = 1'b1; is_match = 1'b1;
      step();
      reset = 1'b0; match_valid = 1'b0; is_match = 1'b0;
      chk("t6_count", found_count, 0);
      chk("t6_pair", pair_ready, 0);
      chk("t6_busy", busy, 0);
      chk("t6_leds_reset", LEDs, 0);
      step();
      chk("t6_leds_mask0", LEDs, 32'h0080);

      // Out-of-range cursor on the 3x4 grid
      cursor_s = 4'd12;
      step();
      chk("oor_leds12", LEDs_s, 0);
      cursor_s = 4'd11;
      step();
      chk("oor_leds11", LEDs_s, 32'h800);
      cursor_s = 4'd13; select_s = 1'b1;
      step();
      select_s = 1'b0;
      step();
      chk("oor_leds13", LEDs_s, 0);
      chk("oor_pick_ignored", card1_s, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
